spi_regfile_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared register file behind the SPI slave. It serialises accesses from the SPI slave datapath (port S) and the local host bus (port H) into single-word reads and writes. Each access takes a fixed 3 cycles. Port S can lock the register file for the length of a multi-byte SPI burst. The block sits between the SPI slave control unit/shift datapath and the register file, and is the only driver of the register file's write-enable, address and write-data inputs.

---
 rtl/spi_regfile_arbiter.sv | 130 +++++++++++++
 tb/tb_spi_regfile_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_arbiter.sv
// spi_regfile_arbiter: two-port (SPI slave / host) 3-cycle access sequencer for the shared register file.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin tie break; fixed S priority when undefined).
`default_nettype none

module spi_regfile_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              S_REQ,
   input  logic              S_WE,
   input  logic [ADDR_W-1:0] S_ADDR,
   input  logic [DATA_W-1:0] S_WDATA,
   input  logic              S_LOCK,
   output logic              S_ACK,
   output logic [DATA_W-1:0] S_RDATA,
   input  logic              H_REQ,
   input  logic              H_WE,
   input  logic [ADDR_W-1:0] H_ADDR,
   input  logic [DATA_W-1:0] H_WDATA,
   output logic              H_ACK,
   output logic [DATA_W-1:0] H_RDATA,
   output logic              RF_WE,
   output logic [ADDR_W-1:0] RF_ADDR,
   output logic [DATA_W-1:0] RF_WDATA,
   input  logic [DATA_W-1:0] RF_RDATA,
   output logic              BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t              state_q;
   logic                win_h_q;
   logic                s_ack_q;
   logic                h_ack_q;
   logic                rf_we_q;
   logic [ADDR_W-1:0]   rf_addr_q;
   logic [DATA_W-1:0]   rf_wdata_q;
   logic [DATA_W-1:0]   s_rdata_q;
   logic [DATA_W-1:0]   h_rdata_q;

   logic                s_elig;
   logic                h_elig;
   logic                pick_h;

   assign s_elig = S_REQ;
   assign h_elig = H_REQ & ~S_LOCK;

`ifdef ARB_ROUND_ROBIN_EN
   // Pointer remembers who won the most recent grant; a tie goes to the other port.
   logic last_h_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         last_h_q <= 1'b1;
      end else if (state_q == ST_IDLE && (s_elig || h_elig)) begin
         last_h_q <= pick_h;
      end
   end

   assign pick_h = h_elig & (~s_elig | ~last_h_q);
`else
   assign pick_h = h_elig & ~s_elig;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         win_h_q    <= 1'b0;
         s_ack_q    <= 1'b0;
         h_ack_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_addr_q  <= '0;
         rf_wdata_q <= '0;
         s_rdata_q  <= '0;
         h_rdata_q  <= '0;
      end else begin
         s_ack_q <= 1'b0;
         h_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s_elig || h_elig) begin
                  win_h_q    <= pick_h;
                  rf_we_q    <= pick_h ? H_WE    : S_WE;
                  rf_addr_q  <= pick_h ? H_ADDR  : S_ADDR;
                  rf_wdata_q <= pick_h ? H_WDATA : S_WDATA;
                  state_q    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // rf_we_q still carries the latched WE here, so it doubles as the read/write flag.
               rf_we_q <= 1'b0;
               if (!rf_we_q) begin
                  if (win_h_q) begin
                     h_rdata_q <= RF_RDATA;
                  end else begin
                     s_rdata_q <= RF_RDATA;
                  end
               end
               s_ack_q <= ~win_h_q;
               h_ack_q <= win_h_q;
               state_q <= ST_RESP;
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign S_ACK    = s_ack_q;
   assign H_ACK    = h_ack_q;
   assign S_RDATA  = s_rdata_q;
   assign H_RDATA  = h_rdata_q;
   assign RF_WE    = rf_we_q;
   assign RF_ADDR  = rf_addr_q;
   assign RF_WDATA = rf_wdata_q;
   assign BUSY     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_regfile_arbiter.sv
// tb_spi_regfile_arbiter: scoreboard bench for spi_regfile_arbiter with a register-file model and randomized traffic.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
`default_nettype none

module tb_spi_regfile_arbiter;

   localparam int AW = 6;
   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          S_REQ = 1'b0, S_WE = 1'b0, S_LOCK = 1'b0;
   logic [AW-1:0] S_ADDR = '0;
   logic [DW-1:0] S_WDATA = '0;
   logic          H_REQ = 1'b0, H_WE = 1'b0;
   logic [AW-1:0] H_ADDR = '0;
   logic [DW-1:0] H_WDATA = '0;
   logic          S_ACK, H_ACK, RF_WE, BUSY;
   logic [DW-1:0] S_RDATA, H_RDATA, RF_WDATA, RF_RDATA;
   logic [AW-1:0] RF_ADDR;

   spi_regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK(CLK), .RST(RST),
      .S_REQ(S_REQ), .S_WE(S_WE), .S_ADDR(S_ADDR), .S_WDATA(S_WDATA), .S_LOCK(S_LOCK),
      .S_ACK(S_ACK), .S_RDATA(S_RDATA),
      .H_REQ(H_REQ), .H_WE(H_WE), .H_ADDR(H_ADDR), .H_WDATA(H_WDATA),
      .H_ACK(H_ACK), .H_RDATA(H_RDATA),
      .RF_WE(RF_WE), .RF_ADDR(RF_ADDR), .RF_WDATA(RF_WDATA), .RF_RDATA(RF_RDATA),
      .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Register file environment: synchronous write, asynchronous read, not cleared by reset.
   logic [DW-1:0] rf [64];
   always @(posedge CLK) if (RF_WE) rf[RF_ADDR] <= RF_WDATA;
   assign RF_RDATA = rf[RF_ADDR];

   // Reference model state
   logic [DW-1:0] mem_m [64];
   logic [DW-1:0] s_last_m = '0, h_last_m = '0;
   bit            last_h_m = 1'b1;
   logic [DW-1:0] sq [$];
   logic [DW-1:0] hq [$];
   logic [13:0]   wq [$];

   int total = 0, bad = 0;
   int s_ack_cnt = 0, h_ack_cnt = 0, we_cnt = 0;
   int s_ack_cyc = 0, h_ack_cyc = 0, we_cyc = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void model_op(bit is_h, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
      if (we) begin
         mem_m[a] = d;
         wq.push_back({a, d});
      end else if (is_h) begin
         h_last_m = mem_m[a];
      end else begin
         s_last_m = mem_m[a];
      end
      if (is_h) hq.push_back(h_last_m);
      else      sq.push_back(s_last_m);
      last_h_m = is_h;
   endfunction

   function automatic bit tie_s_first();
`ifdef ARB_ROUND_ROBIN_EN
      return last_h_m;
`else
      return 1'b1;
`endif
   endfunction

   // Monitor: pops expectations whenever the DUT presents an ACK or a write strobe.
   always @(negedge CLK) begin
      logic [DW-1:0] e;
      logic [13:0]   w;
      if (S_ACK) begin
         s_ack_cnt++;
         s_ack_cyc = cyc;
         if (sq.size() == 0) check("s_ack_unexpected", S_ACK, 0);
         else begin e = sq.pop_front(); check("s_rdata", S_RDATA, e); end
      end
      if (H_ACK) begin
         h_ack_cnt++;
         h_ack_cyc = cyc;
         if (hq.size() == 0) check("h_ack_unexpected", H_ACK, 0);
         else begin e = hq.pop_front(); check("h_rdata", H_RDATA, e); end
      end
      if (RF_WE) begin
         we_cnt++;
         we_cyc = cyc;
         if (wq.size() == 0) check("rf_we_unexpected", RF_WE, 0);
         else begin
            w = wq.pop_front();
            check("rf_addr", RF_ADDR, w[13:8]);
            check("rf_wdata", RF_WDATA, w[7:0]);
         end
      end
   end

   task automatic drive_s(bit we, logic [AW-1:0] a, logic [DW-1:0] d, bit hold);
      int n = 0;
      S_WE = we; S_ADDR = a; S_WDATA = d; S_REQ = 1'b1;
      while (n < 40) begin
         @(negedge CLK);
         if (S_ACK) break;
         n++;
      end
      if (n >= 40) check("s_ack_timeout", S_ACK, 1);
      @(posedge CLK); #1;
      if (hold) begin @(posedge CLK); #1; end
      S_REQ = 1'b0;
   endtask

   task automatic drive_h(bit we, logic [AW-1:0] a, logic [DW-1:0] d, bit hold);
      int n = 0;
      H_WE = we; H_ADDR = a; H_WDATA = d; H_REQ = 1'b1;
      while (n < 40) begin
         @(negedge CLK);
         if (H_ACK) break;
         n++;
      end
      if (n >= 40) check("h_ack_timeout", H_ACK, 1);
      @(posedge CLK); #1;
      if (hold) begin @(posedge CLK); #1; end
      H_REQ = 1'b0;
   endtask

   // Both ports request in the same cycle; the model decides the grant order.
   task automatic pair(bit swe, logic [AW-1:0] sa, logic [DW-1:0] sd,
                       bit hwe, logic [AW-1:0] ha, logic [DW-1:0] hd, bit chk_time);
      int  k = cyc;
      bit  s_first = tie_s_first();
      if (s_first) begin model_op(0, swe, sa, sd); model_op(1, hwe, ha, hd); end
      else         begin model_op(1, hwe, ha, hd); model_op(0, swe, sa, sd); end
      fork
         drive_s(swe, sa, sd, 1'b0);
         drive_h(hwe, ha, hd, 1'b0);
      join
      if (chk_time) begin
         check("tie_s_ack_cycle", s_ack_cyc, s_first ? k + 2 : k + 5);
         check("tie_h_ack_cycle", h_ack_cyc, s_first ? k + 5 : k + 2);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int k, a, f, n, kd, h0;
      for (int i = 0; i < 64; i++) begin rf[i] = '0; mem_m[i] = '0; end

      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_s_ack", S_ACK, 0);
      check("rst_h_ack", H_ACK, 0);
      check("rst_rf_we", RF_WE, 0);
      check("rst_busy", BUSY, 0);
      check("rst_s_rdata", S_RDATA, 0);
      check("rst_h_rdata", H_RDATA, 0);
      check("rst_rf_addr", RF_ADDR, 0);
      check("rst_rf_wdata", RF_WDATA, 0);
      @(posedge CLK); #1;

      // Host write then read-back
      k = cyc; a = we_cnt;
      model_op(1, 1, 6'h05, 8'hA5);
      drive_h(1, 6'h05, 8'hA5, 0);
      check("hwr_ack_cycle", h_ack_cyc, k + 2);
      check("hwr_we_cycle", we_cyc, k + 1);
      check("hwr_we_count", we_cnt, a + 1);
      model_op(1, 0, 6'h05, 8'h00);
      drive_h(0, 6'h05, 8'h00, 0);

      model_op(0, 1, 6'h06, 8'h5C);
      drive_s(1, 6'h06, 8'h5C, 0);

      // Two read ties in a row
      pair(0, 6'h05, 8'h00, 0, 6'h06, 8'h00, 1);
      pair(0, 6'h06, 8'h00, 0, 6'h05, 8'h00, 1);

      // S burst under lock with host waiting
      S_LOCK = 1'b1;
      k = cyc; h0 = h_ack_cnt; kd = 0;
      for (int i = 0; i < 3; i++) model_op(0, 1, 6'(8'h10 + i), 8'(8'h31 + i));
      model_op(1, 0, 6'h11, 8'h00);
      fork
         drive_h(0, 6'h11, 8'h00, 0);
         begin
            for (int i = 0; i < 3; i++) drive_s(1, 6'(8'h10 + i), 8'(8'h31 + i), 0);
            while (cyc < k + 20) begin @(posedge CLK); #1; end
            check("h_ack_during_lock", h_ack_cnt, h0);
            S_LOCK = 1'b0;
            kd = cyc;
         end
      join
      check("lock_h_ack_cycle", h_ack_cyc, kd + 2);

      // Reset while an S read is in ACCESS
      S_WE = 1'b0; S_ADDR = 6'h10; S_REQ = 1'b1;
      @(posedge CLK); #1;
      check("rst_mid_busy_before", BUSY, 1);
      RST = 1'b1; S_REQ = 1'b0;
      a = s_ack_cnt;
      @(posedge CLK); #1;
      RST = 1'b0;
      s_last_m = '0; h_last_m = '0; last_h_m = 1'b1;
      @(negedge CLK);
      check("rst_mid_busy", BUSY, 0);
      check("rst_mid_s_rdata", S_RDATA, 0);
      check("rst_mid_rf_we", RF_WE, 0);
      repeat (4) @(negedge CLK);
      check("rst_mid_no_ack", s_ack_cnt, a);
      @(posedge CLK); #1;

      // Same-address write collision then read-back
      pair(1, 6'h3F, 8'h11, 1, 6'h3F, 8'h22, 1);
      model_op(1, 0, 6'h3F, 8'h00);
      drive_h(0, 6'h3F, 8'h00, 0);
`ifndef ARB_ROUND_ROBIN_EN
      check("collision_last_writer", H_RDATA, 8'h22);
`endif

      // REQ held one cycle past ACK yields a second access
      a = h_ack_cnt;
      model_op(1, 0, 6'h3F, 8'h00);
      model_op(1, 0, 6'h3F, 8'h00);
      drive_h(0, 6'h3F, 8'h00, 1);
      f = h_ack_cyc;
      n = 0;
      while (h_ack_cnt < a + 2 && n < 10) begin @(negedge CLK); n++; end
      check("level_req_second_ack", h_ack_cnt, a + 2);
      check("level_req_ack_spacing", h_ack_cyc, f + 3);
      @(posedge CLK); #1;

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         int            mode = $urandom_range(0, 2);
         bit            swe  = 1'($urandom_range(0, 1));
         bit            hwe  = 1'($urandom_range(0, 1));
         logic [AW-1:0] sa   = 6'($urandom_range(0, 7));
         logic [AW-1:0] ha   = 6'($urandom_range(0, 7));
         logic [DW-1:0] sd   = 8'($urandom);
         logic [DW-1:0] hd   = 8'($urandom);
         if (mode == 0) begin
            model_op(0, swe, sa, sd);
            drive_s(swe, sa, sd, 0);
         end else if (mode == 1) begin
            model_op(1, hwe, ha, hd);
            drive_h(hwe, ha, hd, 0);
         end else begin
            pair(swe, sa, sd, hwe, ha, hd, 1);
         end
      end

      repeat (4) @(negedge CLK);
      check("s_queue_drained", sq.size(), 0);
      check("h_queue_drained", hq.size(), 0);
      check("w_queue_drained", wq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
